// File: rtl/ex_fu_pool_pkg.sv
// Shared types for the execution-unit pool: op kinds, lane states and the
// ROB-age compare used by selective kill.
package ex_fu_pool_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_MUL  = 2'd1,
      OP_FMA  = 2'd2,
      OP_PASS = 2'd3
   } op_kind_e;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'd0,
      LANE_BUSY = 2'd1,
      LANE_DONE = 2'd2
   } lane_state_e;

   // True when rob is strictly younger than kill_rob, both measured as the
   // distance from the ROB head modulo 2^w (so the branch itself survives).
   function automatic logic is_younger(input logic [31:0] rob,
                                       input logic [31:0] kill_rob,
                                       input logic [31:0] head,
                                       input int unsigned w);
      logic [31:0] mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return ((rob - head) & mask) > ((kill_rob - head) & mask);
   endfunction

endpackage

// File: rtl/ex_fu_pool_if.sv
// Issue and writeback buses of the execution-unit pool. The pool is the
// slave; the issue queue / writeback side is the master.
interface ex_fu_pool_if #(
   parameter int ISSUE_W   = 2,
   parameter int NUM_LANES = 2,
   parameter int XLEN      = 64,
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 8
);
   logic [ISSUE_W-1:0]               iss_valid_i;
   logic [ISSUE_W-1:0]               iss_ready_o;
   logic [ISSUE_W-1:0][XLEN-1:0]     iss_op1_i;
   logic [ISSUE_W-1:0][XLEN-1:0]     iss_op2_i;
   logic [ISSUE_W-1:0][XLEN-1:0]     iss_op3_i;
   logic [ISSUE_W-1:0][PREG_W-1:0]   iss_dest_i;
   logic [ISSUE_W-1:0][ROB_W-1:0]    iss_rob_i;

   logic [NUM_LANES-1:0]             wb_valid_o;
   logic [NUM_LANES-1:0]             wb_ready_i;
   logic [NUM_LANES-1:0][XLEN-1:0]   wb_data_o;
   logic [NUM_LANES-1:0][PREG_W-1:0] wb_dest_o;
   logic [NUM_LANES-1:0][ROB_W-1:0]  wb_rob_o;

   modport master (
      output iss_valid_i, iss_op1_i, iss_op2_i, iss_op3_i, iss_dest_i, iss_rob_i,
      output wb_ready_i,
      input  iss_ready_o, wb_valid_o, wb_data_o, wb_dest_o, wb_rob_o
   );

   modport slave (
      input  iss_valid_i, iss_op1_i, iss_op2_i, iss_op3_i, iss_dest_i, iss_rob_i,
      input  wb_ready_i,
      output iss_ready_o, wb_valid_o, wb_data_o, wb_dest_o, wb_rob_o
   );
endinterface

// File: rtl/ex_fu_pool_alu.sv
// Combinational datapath for one issue port; the op kind is fixed per
// instance. Multiplies are unsigned and truncated to XLEN.
module ex_fu_pool_alu
   import ex_fu_pool_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int OP_KIND = 0
) (
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [XLEN-1:0] op3_i,
   output logic [XLEN-1:0] res_o
);
   localparam op_kind_e KIND = op_kind_e'(OP_KIND[1:0]);

   // Select the result for this instance's op kind.
   always_comb begin
      case (KIND)
         OP_ADD:  res_o = op1_i + op2_i;
         OP_MUL:  res_o = op1_i * op2_i;
         OP_FMA:  res_o = op1_i * op2_i + op3_i;
         default: res_o = op2_i;
      endcase
   end
endmodule

// File: rtl/ex_fu_pool.sv
// Pool of NUM_LANES fixed-latency lanes of one FU class. Results are
// computed at issue and parked in the lane until writeback handshakes.
// Optional performance counters: define EX_FU_POOL_PERF_EN.
//
//   state | meaning
//   IDLE  | lane free, allocatable
//   BUSY  | op in flight, countdown running
//   DONE  | result on wb bus, waiting for wb_ready_i
module ex_fu_pool
   import ex_fu_pool_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int ISSUE_W   = 2,
   parameter int LATENCY   = 1,
   parameter int OP_KIND   = 0,
   parameter int XLEN      = 64,
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush_i,
   input  logic                           kill_valid_i,
   input  logic [ROB_W-1:0]               kill_rob_i,
   input  logic [ROB_W-1:0]               rob_head_i,
   ex_fu_pool_if.slave                    bus,
   output logic [$clog2(NUM_LANES+1)-1:0] free_cnt_o,
   output logic [31:0]                    perf_issued_o,
   output logic [31:0]                    perf_stall_o,
   output logic [31:0]                    perf_bp_o
);
   localparam int FC_W   = $clog2(NUM_LANES + 1);
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int PORT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

   typedef struct packed {
      lane_state_e       state;
      logic [CNT_W-1:0]  cnt;
      logic [XLEN-1:0]   data;
      logic [PREG_W-1:0] dest;
      logic [ROB_W-1:0]  rob;
   } lane_t;

   lane_t lane_q [NUM_LANES];
   lane_t lane_d [NUM_LANES];

   logic [ISSUE_W-1:0][XLEN-1:0]     alu_res;
   logic [FC_W-1:0]                  free_cnt;
   logic [ISSUE_W-1:0]               iss_ready;
   logic [NUM_LANES-1:0]             alloc_vld;
   logic [NUM_LANES-1:0][PORT_W-1:0] alloc_port;
   int unsigned                      n_lower;
   logic                             found;

   for (genvar k = 0; k < ISSUE_W; k++) begin : g_alu
      ex_fu_pool_alu #(.XLEN(XLEN), .OP_KIND(OP_KIND)) u_alu (
         .op1_i (bus.iss_op1_i[k]),
         .op2_i (bus.iss_op2_i[k]),
         .op3_i (bus.iss_op3_i[k]),
         .res_o (alu_res[k])
      );
   end

   // Count lanes that are IDLE in registered state.
   always_comb begin
      free_cnt = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (lane_q[l].state == LANE_IDLE) free_cnt = free_cnt + FC_W'(1);
      end
   end

   // Ready depends only on free count and lower valids; the n-th valid port
   // takes the n-th IDLE lane in ascending order.
   always_comb begin
      iss_ready  = '0;
      alloc_vld  = '0;
      alloc_port = '0;
      n_lower    = 0;
      found      = 1'b0;
      for (int k = 0; k < ISSUE_W; k++) begin
         iss_ready[k] = 32'(free_cnt) > n_lower;
         if (bus.iss_valid_i[k]) begin
            n_lower = n_lower + 1;
            if (iss_ready[k]) begin
               found = 1'b0;
               for (int l = 0; l < NUM_LANES; l++) begin
                  if (!found && lane_q[l].state == LANE_IDLE && !alloc_vld[l]) begin
                     alloc_vld[l]  = 1'b1;
                     alloc_port[l] = PORT_W'(k);
                     found         = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Lane next state: normal progress, then kill, then flush on top.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_d[l] = lane_q[l];
         case (lane_q[l].state)
            LANE_IDLE: begin
               if (alloc_vld[l]) begin
                  lane_d[l].data = alu_res[alloc_port[l]];
                  lane_d[l].dest = bus.iss_dest_i[alloc_port[l]];
                  lane_d[l].rob  = bus.iss_rob_i[alloc_port[l]];
                  if (LATENCY == 1) begin
                     lane_d[l].state = LANE_DONE;
                     lane_d[l].cnt   = '0;
                  end else begin
                     lane_d[l].state = LANE_BUSY;
                     lane_d[l].cnt   = CNT_W'(LATENCY - 1);
                  end
               end
            end
            LANE_BUSY: begin
               // Countdown reaching zero lands the result exactly LATENCY
               // cycles after the accepting edge.
               if (lane_q[l].cnt <= CNT_W'(1)) begin
                  lane_d[l].state = LANE_DONE;
                  lane_d[l].cnt   = '0;
               end else begin
                  lane_d[l].cnt = lane_q[l].cnt - CNT_W'(1);
               end
            end
            LANE_DONE: begin
               if (bus.wb_ready_i[l]) lane_d[l].state = LANE_IDLE;
            end
            default: lane_d[l].state = LANE_IDLE;
         endcase

         // Checked on the post-issue view so ops accepted this cycle are
         // killed as well.
         if (kill_valid_i && lane_d[l].state != LANE_IDLE &&
             is_younger(32'(lane_d[l].rob), 32'(kill_rob_i), 32'(rob_head_i), ROB_W)) begin
            lane_d[l].state = LANE_IDLE;
         end
         if (flush_i) lane_d[l].state = LANE_IDLE;
      end
   end

   // Lane state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   // Outputs straight from registered lane contents.
   always_comb begin
      bus.wb_valid_o  = '0;
      bus.wb_data_o   = '0;
      bus.wb_dest_o   = '0;
      bus.wb_rob_o    = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bus.wb_valid_o[l] = (lane_q[l].state == LANE_DONE);
         bus.wb_data_o[l]  = lane_q[l].data;
         bus.wb_dest_o[l]  = lane_q[l].dest;
         bus.wb_rob_o[l]   = lane_q[l].rob;
      end
      bus.iss_ready_o = iss_ready;
      free_cnt_o      = free_cnt;
   end

`ifdef EX_FU_POOL_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_bp_q, perf_bp_d;
   logic [32:0] issued_sum;

   // Saturating event counters; flush does not clear them.
   always_comb begin
      issued_sum    = {1'b0, perf_issued_q} + 33'($countones(bus.iss_valid_i & iss_ready));
      perf_issued_d = issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
      perf_stall_d  = perf_stall_q;
      perf_bp_d     = perf_bp_q;
      if (|(bus.iss_valid_i & ~iss_ready) && perf_stall_q != 32'hFFFF_FFFF)
         perf_stall_d = perf_stall_q + 32'd1;
      if (|(bus.wb_valid_o & ~bus.wb_ready_i) && perf_bp_q != 32'hFFFF_FFFF)
         perf_bp_d = perf_bp_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
         perf_bp_q     <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
         perf_bp_q     <= perf_bp_d;
      end
   end

   assign perf_issued_o = perf_issued_q;
   assign perf_stall_o  = perf_stall_q;
   assign perf_bp_o     = perf_bp_q;
`else
   assign perf_issued_o = '0;
   assign perf_stall_o  = '0;
   assign perf_bp_o     = '0;
`endif

endmodule

// File: tb/tb_ex_fu_pool.sv
// Bench for ex_fu_pool: 2 lanes, 3 issue ports, latency 3, fma op kind.
module tb_ex_fu_pool;
   import ex_fu_pool_pkg::*;

   localparam int NL  = 2;
   localparam int IW  = 3;
   localparam int LAT = 3;
   localparam int OPK = 2;
   localparam int XL  = 64;
   localparam int PW  = 7;
   localparam int RW  = 8;

`ifdef EX_FU_POOL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          kill_valid_i;
   logic [RW-1:0] kill_rob_i;
   logic [RW-1:0] rob_head_i;
   logic [1:0]    free_cnt_o;
   logic [31:0]   perf_issued_o, perf_stall_o, perf_bp_o;

   ex_fu_pool_if #(.ISSUE_W(IW), .NUM_LANES(NL), .XLEN(XL), .PREG_W(PW), .ROB_W(RW)) bus ();

   ex_fu_pool #(.NUM_LANES(NL), .ISSUE_W(IW), .LATENCY(LAT), .OP_KIND(OPK),
                .XLEN(XL), .PREG_W(PW), .ROB_W(RW)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .kill_valid_i  (kill_valid_i),
      .kill_rob_i    (kill_rob_i),
      .rob_head_i    (rob_head_i),
      .bus           (bus),
      .free_cnt_o    (free_cnt_o),
      .perf_issued_o (perf_issued_o),
      .perf_stall_o  (perf_stall_o),
      .perf_bp_o     (perf_bp_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] op1, op2, op3;
      logic [6:0]  dest;
      logic [7:0]  rob;
      logic [63:0] exp;
   } vec_t;
   vec_t vt [5];

   // behavioural model state: which lanes hold a live op and when it lands
   bit          m_act  [NL];
   int          m_done [NL];
   logic [63:0] m_data [NL];
   logic [6:0]  m_dest [NL];
   logic [7:0]  m_rob  [NL];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.iss_valid_i = '0;
      bus.iss_op1_i   = '0;
      bus.iss_op2_i   = '0;
      bus.iss_op3_i   = '0;
      bus.iss_dest_i  = '0;
      bus.iss_rob_i   = '0;
      flush_i         = 1'b0;
      kill_valid_i    = 1'b0;
   endtask

   task automatic drive_port(input int k, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [6:0] d, input logic [7:0] r);
      bus.iss_valid_i[k] = 1'b1;
      bus.iss_op1_i[k]   = a;
      bus.iss_op2_i[k]   = b;
      bus.iss_op3_i[k]   = c;
      bus.iss_dest_i[k]  = d;
      bus.iss_rob_i[k]   = r;
   endtask

   function automatic logic [63:0] golden(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
      logic [63:0] p;
      p = a * b;
      return p + c;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          found;
      int          lat;
      int          cyc;
      int          nfree, nv;
      int          fl [NL];
      logic [IW-1:0] exp_rdy;
      logic [NL-1:0] exp_wbv;
      logic [7:0]  ka;

      vt[0] = '{64'd5, 64'd7, 64'd0, 7'd9, 8'd4, 64'd35};
      vt[1] = '{64'h8000_0000_0000_0000, 64'd2, 64'd1, 7'd20, 8'd100, 64'd1};
      vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 7'd127, 8'd255, 64'd1};
      vt[3] = '{64'd0, 64'h1234, 64'd42, 7'd0, 8'd0, 64'd42};
      vt[4] = '{64'd3, 64'd4, 64'd5, 7'd64, 8'd128, 64'd17};

      rst = 1'b1;
      clear_in();
      bus.wb_ready_i = '1;
      kill_rob_i     = '0;
      rob_head_i     = '0;
      repeat (3) tick();
      rst = 1'b0;

      // reset state, then three valid ports onto two lanes
      drive_port(0, 64'd5, 64'd7, 64'd0, 7'd9, 8'd4);
      drive_port(1, 64'd1, 64'd1, 64'd1, 7'd10, 8'd5);
      drive_port(2, 64'd2, 64'd2, 64'd2, 7'd11, 8'd6);
      @(negedge clk);
      chk("rst_wb_valid", bus.wb_valid_o, 0);
      chk("rst_wb_data0", bus.wb_data_o[0], 0);
      chk("rst_wb_dest1", bus.wb_dest_o[1], 0);
      chk("rst_wb_rob0", bus.wb_rob_o[0], 0);
      chk("rst_free_cnt", free_cnt_o, 2);
      chk("rst_perf_issued", perf_issued_o, 0);
      chk("rst_perf_bp", perf_bp_o, 0);
      chk("three_port_ready", bus.iss_ready_o, 3'b011);
      tick();
      clear_in();
      drive_port(0, 64'd9, 64'd9, 64'd9, 7'd1, 8'd1);
      @(negedge clk);
      chk("full_free_cnt", free_cnt_o, 0);
      chk("full_ready", bus.iss_ready_o, 3'b000);
      tick();
      clear_in();
      @(negedge clk);
      chk("early_wb_valid", bus.wb_valid_o, 2'b00);
      tick();
      @(negedge clk);
      chk("pair_wb_valid", bus.wb_valid_o, 2'b11);
      chk("pair_data0", bus.wb_data_o[0], 35);
      chk("pair_dest0", bus.wb_dest_o[0], 9);
      chk("pair_rob0", bus.wb_rob_o[0], 4);
      chk("pair_data1", bus.wb_data_o[1], 2);
      chk("pair_dest1", bus.wb_dest_o[1], 10);
      chk("pair_rob1", bus.wb_rob_o[1], 5);
      tick();
      @(negedge clk);
      chk("pair_freed", free_cnt_o, 2);
      chk("pair_wb_clear", bus.wb_valid_o, 2'b00);
      tick();

      // table of single issues: latency, arithmetic and tag carry-through
      for (int i = 0; i < 5; i++) begin
         clear_in();
         drive_port(0, vt[i].op1, vt[i].op2, vt[i].op3, vt[i].dest, vt[i].rob);
         @(negedge clk);
         chk("tbl_ready", bus.iss_ready_o[0], 1);
         tick();
         clear_in();
         found = 1'b0;
         lat   = 0;
         for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            chk("tbl_free_busy", free_cnt_o, 1);
            if (bus.wb_valid_o[0]) begin
               found = 1'b1;
               lat   = c;
            end else begin
               tick();
            end
         end
         chk("tbl_latency", lat, LAT);
         chk("tbl_data", bus.wb_data_o[0], vt[i].exp);
         chk("tbl_dest", bus.wb_dest_o[0], vt[i].dest);
         chk("tbl_rob", bus.wb_rob_o[0], vt[i].rob);
         tick();
         @(negedge clk);
         chk("tbl_freed", free_cnt_o, 2);
         chk("tbl_wb_clear", bus.wb_valid_o, 0);
         tick();
      end

      // writeback backpressure for four cycles
      clear_in();
      bus.wb_ready_i = 2'b00;
      drive_port(0, 64'd6, 64'd7, 64'd1, 7'd3, 8'd7);
      tick();
      clear_in();
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus.wb_valid_o[0], 1);
         chk("bp_hold_data", bus.wb_data_o[0], 43);
         chk("bp_hold_dest", bus.wb_dest_o[0], 3);
         tick();
      end
      bus.wb_ready_i = 2'b11;
      @(negedge clk);
      chk("bp_release_valid", bus.wb_valid_o[0], 1);
      tick();
      @(negedge clk);
      chk("bp_after_valid", bus.wb_valid_o, 0);
      chk("bp_after_free", free_cnt_o, 2);
      chk("perf_bp", perf_bp_o, PERF ? 64'd4 : 64'd0);
      chk("perf_issued", perf_issued_o, PERF ? 64'd8 : 64'd0);
      chk("perf_stall", perf_stall_o, PERF ? 64'd2 : 64'd0);
      tick();

      // kill with ROB wrap, issues in the kill cycle
      clear_in();
      rob_head_i = 8'd250;
      drive_port(0, 64'd1, 64'd1, 64'd0, 7'd1, 8'd252);
      drive_port(1, 64'd1, 64'd2, 64'd0, 7'd2, 8'd3);
      kill_valid_i = 1'b1;
      kill_rob_i   = 8'd254;
      @(negedge clk);
      chk("kill_issue_ready", bus.iss_ready_o, 3'b011);
      tick();
      clear_in();
      @(negedge clk);
      chk("kill_wrap_free", free_cnt_o, 1);
      tick();
      tick();
      @(negedge clk);
      chk("kill_wrap_wbv", bus.wb_valid_o, 2'b01);
      chk("kill_wrap_rob", bus.wb_rob_o[0], 252);
      tick();
      // kill on in-flight lanes: equal age survives, younger dropped
      drive_port(0, 64'd2, 64'd2, 64'd0, 7'd5, 8'd254);
      drive_port(1, 64'd2, 64'd3, 64'd0, 7'd6, 8'd255);
      tick();
      clear_in();
      kill_valid_i = 1'b1;
      kill_rob_i   = 8'd254;
      @(negedge clk);
      chk("kill_same_cycle_free", free_cnt_o, 0);
      tick();
      clear_in();
      @(negedge clk);
      chk("kill_busy_free", free_cnt_o, 1);
      tick();
      @(negedge clk);
      chk("kill_busy_wbv", bus.wb_valid_o, 2'b01);
      chk("kill_busy_rob", bus.wb_rob_o[0], 254);
      tick();

      // flush with both lanes busy and issue attempts
      clear_in();
      drive_port(0, 64'd1, 64'd1, 64'd1, 7'd1, 8'd1);
      drive_port(1, 64'd1, 64'd1, 64'd1, 7'd2, 8'd2);
      tick();
      clear_in();
      flush_i = 1'b1;
      drive_port(0, 64'd1, 64'd1, 64'd1, 7'd3, 8'd3);
      drive_port(1, 64'd1, 64'd1, 64'd1, 7'd4, 8'd4);
      @(negedge clk);
      chk("flush_ready", bus.iss_ready_o, 3'b000);
      tick();
      clear_in();
      @(negedge clk);
      chk("flush_free", free_cnt_o, 2);
      chk("flush_wbv", bus.wb_valid_o, 0);
      tick();
      tick();
      @(negedge clk);
      chk("flush_wbv_late", bus.wb_valid_o, 0);
      // flush discards an issue accepted the same cycle
      drive_port(0, 64'd1, 64'd1, 64'd1, 7'd1, 8'd1);
      flush_i = 1'b1;
      tick();
      clear_in();
      @(negedge clk);
      chk("flush_issue_free", free_cnt_o, 2);
      tick();

      // randomized traffic against the model
      for (int l = 0; l < NL; l++) m_act[l] = 1'b0;
      cyc = 0;
      for (int it = 0; it < 600; it++) begin
         bus.iss_valid_i = IW'($urandom_range(0, 7));
         for (int k = 0; k < IW; k++) begin
            bus.iss_op1_i[k]  = {$urandom(), $urandom()};
            bus.iss_op2_i[k]  = {$urandom(), $urandom()};
            bus.iss_op3_i[k]  = {$urandom(), $urandom()};
            bus.iss_dest_i[k] = 7'($urandom());
            bus.iss_rob_i[k]  = 8'($urandom());
         end
         bus.wb_ready_i = NL'($urandom_range(0, 3));
         kill_valid_i   = ($urandom_range(0, 7) == 0);
         kill_rob_i     = 8'($urandom());
         rob_head_i     = 8'($urandom());
         flush_i        = ($urandom_range(0, 39) == 0);
         @(negedge clk);

         nfree = 0;
         for (int l = 0; l < NL; l++) begin
            if (!m_act[l]) begin
               fl[nfree] = l;
               nfree++;
            end
         end
         chk("rnd_free_cnt", free_cnt_o, nfree);
         nv = 0;
         exp_rdy = '0;
         for (int k = 0; k < IW; k++) begin
            exp_rdy[k] = (nfree > nv);
            if (bus.iss_valid_i[k]) nv++;
         end
         chk("rnd_ready", bus.iss_ready_o, exp_rdy);
         exp_wbv = '0;
         for (int l = 0; l < NL; l++) exp_wbv[l] = m_act[l] && (cyc >= m_done[l]);
         chk("rnd_wb_valid", bus.wb_valid_o, exp_wbv);
         for (int l = 0; l < NL; l++) begin
            if (exp_wbv[l]) begin
               chk("rnd_wb_data", bus.wb_data_o[l], m_data[l]);
               chk("rnd_wb_dest", bus.wb_dest_o[l], m_dest[l]);
               chk("rnd_wb_rob", bus.wb_rob_o[l], m_rob[l]);
            end
         end

         for (int l = 0; l < NL; l++) begin
            if (exp_wbv[l] && bus.wb_ready_i[l]) m_act[l] = 1'b0;
         end
         nv = 0;
         for (int k = 0; k < IW; k++) begin
            if (bus.iss_valid_i[k]) begin
               if (nv < nfree) begin
                  m_act[fl[nv]]  = 1'b1;
                  m_done[fl[nv]] = cyc + LAT;
                  m_data[fl[nv]] = golden(bus.iss_op1_i[k], bus.iss_op2_i[k], bus.iss_op3_i[k]);
                  m_dest[fl[nv]] = bus.iss_dest_i[k];
                  m_rob[fl[nv]]  = bus.iss_rob_i[k];
               end
               nv++;
            end
         end
         if (kill_valid_i) begin
            ka = kill_rob_i - rob_head_i;
            for (int l = 0; l < NL; l++) begin
               if (m_act[l] && 8'(m_rob[l] - rob_head_i) > ka) m_act[l] = 1'b0;
            end
         end
         if (flush_i) begin
            for (int l = 0; l < NL; l++) m_act[l] = 1'b0;
         end
         tick();
         cyc++;
      end

      // reset in the middle of operation
      clear_in();
      bus.wb_ready_i = '1;
      drive_port(0, 64'd1, 64'd1, 64'd1, 7'd1, 8'd1);
      drive_port(1, 64'd1, 64'd1, 64'd1, 7'd2, 8'd2);
      tick();
      clear_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_free", free_cnt_o, 2);
      chk("midrst_wbv", bus.wb_valid_o, 0);
      chk("midrst_perf_issued", perf_issued_o, 0);
      tick();
      tick();
      @(negedge clk);
      chk("midrst_wbv_late", bus.wb_valid_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
